// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants for the time-of-day counter.
//   Field widths, field limits and the default prescaler divide ratio.
//   Used by rtc_prescaler and rtc_timekeeper.
package rtc_pkg;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

   localparam int CLK_DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides the system clock down to a once-per-second tick.
// Ports:
//   clock   in   system clock (posedge)
//   resetn  in   synchronous active-low reset
//   run     in   1 = divider advances, 0 = divider frozen
//   clear   in   restart the second from 0 (accepted time load)
//   tick    out  high during the last cycle of a second; the consumer
//                registers its own strobe on this edge
module rtc_prescaler
   import rtc_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic clock,
   input  logic resetn,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   assign tick = run && (div == DIV_LAST);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         div <= '0;
      end else if (clear) begin
         div <= '0;
      end else if (run) begin
         if (div == DIV_LAST) div <= '0;
         else                 div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: 24-hour hours/minutes/seconds counter with a 1 Hz strobe.
// Optional load port compiled in with `define RTC_SET_EN.
// Ports:
//   clock        in   system clock (posedge)
//   resetn       in   synchronous active-low reset
//   run          in   1 = timekeeping advances
//   set_valid    in   load request               (RTC_SET_EN)
//   set_hours    in   hours to load, 0-23        (RTC_SET_EN)
//   set_minutes  in   minutes to load, 0-59      (RTC_SET_EN)
//   set_ack      out  pulse: load accepted       (RTC_SET_EN)
//   set_err      out  pulse: load out of range   (RTC_SET_EN)
//   secondClock  out  one-cycle strobe per second; time already updated
//   seconds      out  0-59
//   minutes      out  0-59
//   hours        out  0-23
//   midnight     out  pulse with the strobe that enters 00:00:00
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              run,
`ifdef RTC_SET_EN
   input  logic              set_valid,
   input  logic [HOUR_W-1:0] set_hours,
   input  logic [MIN_W-1:0]  set_minutes,
   output logic              set_ack,
   output logic              set_err,
`endif
   output logic              secondClock,
   output logic [SEC_W-1:0]  seconds,
   output logic [MIN_W-1:0]  minutes,
   output logic [HOUR_W-1:0] hours,
   output logic              midnight
);

   logic tick;
   logic load_ok;

`ifdef RTC_SET_EN
   assign load_ok = set_valid && (set_hours <= HOUR_MAX) && (set_minutes <= MIN_MAX);
`else
   assign load_ok = 1'b0;
`endif

   rtc_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clock  (clock),
      .resetn (resetn),
      .run    (run),
      .clear  (load_ok),
      .tick   (tick)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         seconds     <= '0;
         minutes     <= '0;
         hours       <= '0;
         secondClock <= 1'b0;
         midnight    <= 1'b0;
`ifdef RTC_SET_EN
         set_ack     <= 1'b0;
         set_err     <= 1'b0;
`endif
      end else begin
         secondClock <= 1'b0;
         midnight    <= 1'b0;
`ifdef RTC_SET_EN
         set_ack     <= 1'b0;
         set_err     <= 1'b0;
         if (set_valid && !load_ok) set_err <= 1'b1;
`endif
         if (load_ok) begin
            // A load restarts the second, so a coincident tick is dropped.
`ifdef RTC_SET_EN
            hours   <= set_hours;
            minutes <= set_minutes;
            set_ack <= 1'b1;
`endif
            seconds <= '0;
         end else if (tick) begin
            secondClock <= 1'b1;
            if (seconds == SEC_MAX) begin
               seconds <= '0;
               if (minutes == MIN_MAX) begin
                  minutes <= '0;
                  if (hours == HOUR_MAX) begin
                     hours    <= '0;
                     midnight <= 1'b1;
                  end else begin
                     hours <= hours + 1'b1;
                  end
               end else begin
                  minutes <= minutes + 1'b1;
               end
            end else begin
               seconds <= seconds + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed bench for rtc_timekeeper with CLK_DIV=4.
// Load-port scenarios are exercised when RTC_SET_EN is defined.
module tb_rtc_timekeeper;

   localparam int CLK_DIV = 4;

   logic       clock  = 1'b0;
   logic       resetn = 1'b0;
   logic       run    = 1'b1;
   logic       secondClock;
   logic [5:0] seconds;
   logic [5:0] minutes;
   logic [4:0] hours;
   logic       midnight;
`ifdef RTC_SET_EN
   logic       set_valid   = 1'b0;
   logic [4:0] set_hours   = '0;
   logic [5:0] set_minutes = '0;
   logic       set_ack;
   logic       set_err;
`endif

   rtc_timekeeper #(.CLK_DIV(CLK_DIV)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .run         (run),
`ifdef RTC_SET_EN
      .set_valid   (set_valid),
      .set_hours   (set_hours),
      .set_minutes (set_minutes),
      .set_ack     (set_ack),
      .set_err     (set_err),
`endif
      .secondClock (secondClock),
      .seconds     (seconds),
      .minutes     (minutes),
      .hours       (hours),
      .midnight    (midnight)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time of day as seconds since midnight, plus cycles into the current second.
   int m_tod   = 0;
   int m_phase = 0;
   bit m_sc, m_mid, m_ack, m_err;
   bit m_live  = 0;

   always @(posedge clock) begin
      bit ok;
      ok = 0;
      if (!resetn) begin
         m_tod = 0; m_phase = 0;
         m_sc = 0; m_mid = 0; m_ack = 0; m_err = 0;
         m_live = 1;
      end else begin
         m_sc = 0; m_mid = 0; m_ack = 0; m_err = 0;
`ifdef RTC_SET_EN
         if (set_valid) begin
            if (set_hours <= 23 && set_minutes <= 59) ok = 1;
            else m_err = 1;
         end
         if (ok) begin
            m_tod   = set_hours * 3600 + set_minutes * 60;
            m_phase = 0;
            m_ack   = 1;
         end
`endif
         if (!ok && run) begin
            if (m_phase == CLK_DIV - 1) begin
               m_phase = 0;
               m_tod   = (m_tod + 1) % 86400;
               m_sc    = 1;
               m_mid   = (m_tod == 0);
            end else begin
               m_phase++;
            end
         end
      end
      #1;
      if (m_live) begin
         check("hours",       hours,       m_tod / 3600);
         check("minutes",     minutes,     (m_tod / 60) % 60);
         check("seconds",     seconds,     m_tod % 60);
         check("secondClock", secondClock, m_sc);
         check("midnight",    midnight,    m_mid);
`ifdef RTC_SET_EN
         check("set_ack",     set_ack,     m_ack);
         check("set_err",     set_err,     m_err);
`endif
      end
   end

   initial begin
      // reset state
      repeat (3) @(posedge clock);
      #2;
      check("rst_sec", seconds, 0);
      check("rst_hour", hours, 0);
      check("rst_sc", secondClock, 0);

      // cadence: strobe 4, 8, 12 cycles after release, seconds 1, 2, 3
      @(negedge clock) resetn = 1'b1;
      repeat (4) @(posedge clock);
      #2;
      check("tick1_sc", secondClock, 1);
      check("tick1_sec", seconds, 1);
      repeat (3) @(posedge clock);
      #2;
      check("gap_sc", secondClock, 0);
      @(posedge clock);
      #2;
      check("tick2_sec", seconds, 2);
      repeat (4) @(posedge clock);
      #2;
      check("tick3_sc", secondClock, 1);
      check("tick3_sec", seconds, 3);

`ifdef RTC_SET_EN
      // 23:59 then 60 ticks -> midnight
      @(negedge clock);
      set_valid = 1'b1; set_hours = 5'd23; set_minutes = 6'd59;
      @(posedge clock);
      #2;
      set_valid = 1'b0;
      check("ld2359_ack", set_ack, 1);
      check("ld2359_hr", hours, 23);
      check("ld2359_sec", seconds, 0);
      repeat (240) @(posedge clock);
      #2;
      check("mid_hr", hours, 0);
      check("mid_min", minutes, 0);
      check("mid_sec", seconds, 0);
      check("mid_sc", secondClock, 1);
      check("mid_pulse", midnight, 1);

      // rejected loads
      @(negedge clock);
      set_valid = 1'b1; set_hours = 5'd24; set_minutes = 6'd0;
      @(posedge clock);
      #2;
      set_valid = 1'b0;
      check("bad24_err", set_err, 1);
      check("bad24_hr", hours, 0);
      @(negedge clock);
      set_valid = 1'b1; set_hours = 5'd12; set_minutes = 6'd60;
      @(posedge clock);
      #2;
      set_valid = 1'b0;
      check("bad60_err", set_err, 1);
      check("bad60_ack", set_ack, 0);
      check("bad60_hr", hours, 0);

      // load coincident with prescaler wrap
      for (int i = 0; i < 8 && m_phase != CLK_DIV - 1; i++) @(negedge clock);
      check("wrap_align", m_phase, CLK_DIV - 1);
      set_valid = 1'b1; set_hours = 5'd8; set_minutes = 6'd0;
      @(posedge clock);
      #2;
      set_valid = 1'b0;
      check("ldwrap_ack", set_ack, 1);
      check("ldwrap_sc", secondClock, 0);
      check("ldwrap_hr", hours, 8);
      check("ldwrap_sec", seconds, 0);
      repeat (3) @(posedge clock);
      #2;
      check("ldwrap_gap", secondClock, 0);
      @(posedge clock);
      #2;
      check("ldwrap_next_sc", secondClock, 1);
      check("ldwrap_next_sec", seconds, 1);

      // held set_valid keeps reloading
      @(negedge clock);
      set_valid = 1'b1; set_hours = 5'd5; set_minutes = 6'd30;
      repeat (2) @(posedge clock);
      #2;
      check("held_ack", set_ack, 1);
      set_valid = 1'b0;
`endif

      // run low for 3 cycles with the divider one cycle into the second
      for (int i = 0; i < 8 && m_phase != 1; i++) @(negedge clock);
      check("pause_align", m_phase, 1);
      run = 1'b0;
      repeat (3) @(negedge clock);
      run = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      check("pause_gap", secondClock, 0);
      @(posedge clock);
      #2;
      check("pause_tick", secondClock, 1);

`ifdef RTC_SET_EN
      // reach 13:45:12 then reset mid-period
      @(negedge clock);
      set_valid = 1'b1; set_hours = 5'd13; set_minutes = 6'd45;
      @(posedge clock);
      #2;
      set_valid = 1'b0;
      repeat (48) @(posedge clock);
      #2;
      check("pre_rst_sec", seconds, 12);
      check("pre_rst_min", minutes, 45);
`endif
      repeat (2) @(negedge clock);
      resetn = 1'b0;
      @(posedge clock);
      #2;
      check("midrst_sec", seconds, 0);
      check("midrst_min", minutes, 0);
      check("midrst_hr", hours, 0);
`ifdef RTC_SET_EN
      @(negedge clock);
      set_valid = 1'b1; set_hours = 5'd10; set_minutes = 6'd10;
      @(posedge clock);
      #2;
      check("rstld_ack", set_ack, 0);
      check("rstld_hr", hours, 0);
      set_valid = 1'b0;
`endif
      @(negedge clock);
      resetn = 1'b1;
      repeat (10) @(posedge clock);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
